uart_tx: RTL and testbench

- UART transmitter: serialises one 8-bit byte per request into an 11-bit frame on `tx_out`.
- Frame format: start bit, 8 data bits LSB first, one parity bit, one stop bit.
- Upstream stage of the UART receive path; `tx_out` drives the receiver's serial input directly.
- Fully synchronous to `clk`; bit timing comes from an internal baud counter, with no separate baud clock.

---
 rtl/uart_tx.sv | 73 +++++++
 tb/tb_uart_tx.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter framing start, 8 data bits LSB first, parity and stop.
module uart_tx #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE = 19_200,
  parameter int PARITY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] din,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_out
);
  localparam int BAUD_CLOCK_CYCLES = CLK_FREQUENCY / BAUD_RATE;
  localparam int BW = BAUD_CLOCK_CYCLES > 1 ? $clog2(BAUD_CLOCK_CYCLES) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_CLOCK_CYCLES - 1);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PAR = 3'd3, STOP = 3'd4;
  logic [2:0]    state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic          tc;
  assign tc = baud == BAUD_LAST;
  // done is decoded from registered state so it coincides with the last stop-bit cycle
  assign tx_done = state == STOP && tc;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      busy    <= 1'b0;
      tx_out  <= 1'b1;
    end else begin
      baud <= (state == IDLE || tc) ? '0 : baud + 1'b1;
      case (state)
        IDLE: if (send) begin
          shreg  <= din;
          par    <= ^din ^ PARITY[0];
          state  <= START;
          busy   <= 1'b1;
          tx_out <= 1'b0;
        end
        START: if (tc) begin
          state   <= DATA;
          bit_cnt <= '0;
          tx_out  <= shreg[0];
        end
        DATA: if (tc) begin
          shreg   <= shreg >> 1;
          bit_cnt <= bit_cnt + 1'b1;
          state   <= bit_cnt == 3'd7 ? PAR : DATA;
          tx_out  <= bit_cnt == 3'd7 ? par : shreg[1];
        end
        PAR: if (tc) begin
          state  <= STOP;
          tx_out <= 1'b1;
        end
        STOP: if (tc) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          tx_out <= 1'b1;
        end
      endcase
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with a mid-bit sampling receiver model.
module tb_uart_tx;
  logic clk = 1'b0, clk_en = 1'b0, rst = 1'b0;
  logic send_q = 1'b0, send_e = 1'b0, send_d = 1'b0;
  logic [7:0] din_q = '0, din_e = '0, din_d = '0;
  logic busy_q, busy_e, busy_d, done_q, done_e, done_d, tx_q, tx_e, tx_d;
  int checks = 0, errors = 0, sel = 0, cyc = 0;
  int dcnt_q = 0, dcnt_e = 0, dcnt_d = 0, bcnt_q = 0, bcnt_d = 0;
  logic line;
  uart_tx #(.CLK_FREQUENCY(1_000_000), .BAUD_RATE(100_000), .PARITY(1)) dut_q (
    .clk(clk), .rst(rst), .send(send_q), .din(din_q), .busy(busy_q), .tx_done(done_q), .tx_out(tx_q));
  uart_tx #(.CLK_FREQUENCY(1_000_000), .BAUD_RATE(100_000), .PARITY(0)) dut_e (
    .clk(clk), .rst(rst), .send(send_e), .din(din_e), .busy(busy_e), .tx_done(done_e), .tx_out(tx_e));
  uart_tx dut_d (
    .clk(clk), .rst(rst), .send(send_d), .din(din_d), .busy(busy_d), .tx_done(done_d), .tx_out(tx_d));
  always #5 if (clk_en) clk = ~clk;
  assign line = sel == 0 ? tx_q : sel == 1 ? tx_e : tx_d;
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (done_q) dcnt_q = dcnt_q + 1;
    if (done_e) dcnt_e = dcnt_e + 1;
    if (done_d) dcnt_d = dcnt_d + 1;
    if (busy_q) bcnt_q = bcnt_q + 1;
    if (busy_d) bcnt_d = bcnt_d + 1;
  end
  // Receiver model: finds the start bit, then samples every bit at its centre
  task automatic rx(input int bl, output logic [7:0] d, output logic p, output logic s,
                    output int t0, output logic ok);
    int n = 0;
    ok = 1'b1; d = '0; p = 1'b0; s = 1'b0; t0 = 0;
    while (line !== 1'b0 && n < 20 * bl) begin @(negedge clk); n++; end
    if (line !== 1'b0) begin ok = 1'b0; return; end
    t0 = cyc;
    repeat (bl / 2) @(negedge clk);
    if (line !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin repeat (bl) @(negedge clk); d[i] = line; end
    repeat (bl) @(negedge clk); p = line;
    repeat (bl) @(negedge clk); s = line;
  endtask
  task automatic test_reset;
    logic [8:0] got;
    #1 rst = 1'b1;
    #1 got = {tx_q, busy_q, done_q, tx_e, busy_e, done_e, tx_d, busy_d, done_d};
    checks++;
    if (got !== 9'b100_100_100) begin errors++; $display("FAIL reset_values got %b want 100100100", got); end
    clk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_single;
    logic [7:0] d; logic p, s, ok; int t0, n = 0;
    sel = 0; dcnt_q = 0; bcnt_q = 0;
    din_q = 8'h41; send_q = 1'b1;
    @(negedge clk); send_q = 1'b0; din_q = 8'h00;
    checks++;
    if ({busy_q, tx_q} !== 2'b10) begin errors++; $display("FAIL single_start busy/tx got %b want 10", {busy_q, tx_q}); end
    rx(10, d, p, s, t0, ok);
    while (busy_q && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (!ok) begin errors++; $display("FAIL single_rx_ok got 0 want 1"); end
    checks++;
    if ({d, p, s} !== {8'h41, 2'b11}) begin errors++; $display("FAIL single_frame got %h/%b%b want 41/11", d, p, s); end
    checks++;
    if (bcnt_q !== 110) begin errors++; $display("FAIL single_busy_len got %0d want 110", bcnt_q); end
    checks++;
    if (dcnt_q !== 1) begin errors++; $display("FAIL single_done got %0d want 1", dcnt_q); end
  endtask
  task automatic test_even;
    logic [7:0] d; logic p, s, ok; int t0, n;
    sel = 1; dcnt_e = 0;
    for (int k = 0; k < 2; k++) begin
      din_e = k == 0 ? 8'hFF : 8'h00; send_e = 1'b1;
      @(negedge clk); send_e = 1'b0;
      rx(10, d, p, s, t0, ok);
      n = 0;
      while (busy_e && n < 200) begin @(negedge clk); n++; end
      checks++;
      if (!ok || {d, p, s} !== {din_e, 2'b01}) begin
        errors++; $display("FAIL even_frame%0d got %h/%b%b ok=%b want %h/01", k, d, p, s, ok, din_e);
      end
    end
    checks++;
    if (dcnt_e !== 2) begin errors++; $display("FAIL even_done got %0d want 2", dcnt_e); end
  endtask
  task automatic test_ignored;
    logic [7:0] d; logic p, s, ok; int t0, n = 0, lows = 0;
    sel = 0; dcnt_q = 0; bcnt_q = 0;
    din_q = 8'hA5; send_q = 1'b1;
    @(negedge clk); send_q = 1'b0;
    fork
      rx(10, d, p, s, t0, ok);
      begin
        repeat (35) @(negedge clk);
        din_q = 8'h3C; send_q = 1'b1;
        @(negedge clk); send_q = 1'b0; din_q = 8'hFF;
      end
    join
    while (busy_q && n < 200) begin @(negedge clk); n++; end
    repeat (200) begin @(negedge clk); if (tx_q !== 1'b1 || busy_q !== 1'b0) lows++; end
    checks++;
    if (!ok || {d, p, s} !== {8'hA5, 2'b11}) begin errors++; $display("FAIL ignored_frame got %h/%b%b ok=%b want a5/11", d, p, s, ok); end
    checks++;
    if (lows !== 0) begin errors++; $display("FAIL ignored_no_second got %0d active cycles want 0", lows); end
    checks++;
    if (dcnt_q !== 1 || bcnt_q !== 110) begin errors++; $display("FAIL ignored_done got %0d/%0d want 1/110", dcnt_q, bcnt_q); end
  endtask
  task automatic test_back_to_back;
    logic [7:0] d; logic p, s, ok; int t0, tp, n = 0;
    logic [7:0] exp [3] = '{8'h00, 8'h55, 8'hAA};
    sel = 0; dcnt_q = 0; tp = 0;
    din_q = exp[0]; send_q = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rx(10, d, p, s, t0, ok);
      if (k < 2) din_q = exp[k+1]; else send_q = 1'b0;
      checks++;
      if (!ok || {d, p, s} !== {exp[k], 2'b11}) begin
        errors++; $display("FAIL b2b_frame%0d got %h/%b%b ok=%b want %h/11", k, d, p, s, ok, exp[k]);
      end
      if (k > 0) begin
        checks++;
        if (t0 - tp !== 111) begin errors++; $display("FAIL b2b_spacing%0d got %0d want 111", k, t0 - tp); end
      end
      tp = t0;
    end
    while (busy_q && n < 200) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    checks++;
    if (dcnt_q !== 3) begin errors++; $display("FAIL b2b_done got %0d want 3", dcnt_q); end
  endtask
  task automatic test_reset_mid;
    logic [7:0] d; logic p, s, ok; int t0, n = 0;
    sel = 0; dcnt_q = 0;
    din_q = 8'hF0; send_q = 1'b1;
    @(negedge clk); send_q = 1'b0;
    repeat (45) @(negedge clk);
    checks++;
    if ({busy_q, tx_q} !== 2'b10) begin errors++; $display("FAIL mid_bit3 busy/tx got %b want 10", {busy_q, tx_q}); end
    #2 rst = 1'b1;
    #1 checks++;
    if ({tx_q, busy_q, done_q} !== 3'b100) begin errors++; $display("FAIL mid_async got %b want 100", {tx_q, busy_q, done_q}); end
    @(negedge clk); rst = 1'b0;
    repeat (100) @(negedge clk);
    checks++;
    if (dcnt_q !== 0 || tx_q !== 1'b1 || busy_q !== 1'b0) begin
      errors++; $display("FAIL mid_aborted got done=%0d tx=%b busy=%b want 0/1/0", dcnt_q, tx_q, busy_q);
    end
    din_q = 8'h5A; send_q = 1'b1;
    @(negedge clk); send_q = 1'b0;
    rx(10, d, p, s, t0, ok);
    while (busy_q && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (!ok || {d, p, s} !== {8'h5A, 2'b11} || dcnt_q !== 1) begin
      errors++; $display("FAIL mid_resend got %h/%b%b done=%0d want 5a/11 done=1", d, p, s, dcnt_q);
    end
  endtask
  task automatic test_default;
    logic [7:0] d; logic p, s, ok; int t0, n = 0;
    sel = 2; dcnt_d = 0; bcnt_d = 0;
    din_d = 8'h41; send_d = 1'b1;
    @(negedge clk); send_d = 1'b0;
    rx(5208, d, p, s, t0, ok);
    while (busy_d && n < 10000) begin @(negedge clk); n++; end
    checks++;
    if (!ok || {d, p, s} !== {8'h41, 2'b11}) begin errors++; $display("FAIL default_frame got %h/%b%b ok=%b want 41/11", d, p, s, ok); end
    checks++;
    if (bcnt_d !== 57288 || dcnt_d !== 1) begin errors++; $display("FAIL default_len got %0d/%0d want 57288/1", bcnt_d, dcnt_d); end
  endtask
  initial begin
    test_reset;
    test_single;
    test_even;
    test_ignored;
    test_back_to_back;
    test_reset_mid;
    test_default;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
